// File: rtl/fifo.sv
// Single-clock FIFO, 2**ADDR_WIDTH words of DATA_WIDTH bits, with registered read data.
// Pointers carry one extra wrap bit so full and empty fall straight out of a compare.
module fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                    (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
        rd_accept = rd_en & ~empty;
        wr_accept = wr_en & (~full | rd_en);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                dout   <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    // Storage is never cleared; reset only blocks the write on that edge.
    always_ff @(posedge clk) begin
        if (rst && wr_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus random traffic against a queue model.
module tb_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;

    fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .data  (data),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout;
    int            n_vec  = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive, clock, update the behavioural model, then check all outputs.
    task automatic cyc(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        bit was_full;
        bit was_empty;
        rst   = r;
        wr_en = w;
        rd_en = rd;
        data  = d;
        @(posedge clk);
        if (!r) begin
            q.delete();
            exp_dout = '0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (rd && !was_empty) exp_dout = q.pop_front();
            if (w && (!was_full || rd)) q.push_back(d);
        end
        #1;
        check("dout",  32'(dout),  32'(exp_dout));
        check("full",  32'(full),  32'(q.size() == DEPTH));
        check("empty", 32'(empty), 32'(q.size() == 0));
    endtask

    task automatic push(input logic [DW-1:0] d);
        cyc(1'b1, 1'b1, 1'b0, d);
    endtask

    task automatic pop();
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        logic [DW-1:0] basic [4];
        basic = '{8'hA1, 8'hFF, 8'h00, 8'h53};
        exp_dout = '0;

        // Reset with a write request held: nothing may be stored.
        cyc(1'b0, 1'b1, 1'b0, 8'h5A);
        cyc(1'b0, 1'b1, 1'b0, 8'h5A);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_empty", 32'(empty), 32'd1);

        // Basic ordering, then over-read.
        for (int i = 0; i < 4; i++) push(basic[i]);
        for (int i = 0; i < 10; i++) pop();
        check("basic_last", 32'(dout), 32'h53);

        // Fill, attempt overflow, drain.
        for (int i = 0; i < 16; i++) push(8'(i));
        check("full_set", 32'(full), 32'd1);
        push(8'hEE);
        for (int i = 0; i < 16; i++) pop();
        check("drain_last", 32'(dout), 32'h0F);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
        for (int i = 0; i < 10; i++) pop();
        for (int i = 0; i < 12; i++) push(8'(8'h20 + i));
        for (int i = 0; i < 12; i++) pop();
        check("wrap_last", 32'(dout), 32'h2B);

        // Simultaneous read/write in the middle, when full and when empty.
        push(8'h11); push(8'h22); push(8'h33);
        cyc(1'b1, 1'b1, 1'b1, 8'h44);
        check("simul_mid", 32'(dout), 32'h11);
        for (int i = 0; i < 13; i++) push(8'(8'h50 + i));
        cyc(1'b1, 1'b1, 1'b1, 8'h99);
        check("simul_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) pop();
        check("simul_full_order", 32'(dout), 32'h99);
        cyc(1'b1, 1'b1, 1'b1, 8'h77);
        check("simul_empty_hold", 32'(dout), 32'h99);
        pop();

        // Reset in the middle of traffic.
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        pop();
        check("midrst_dout", 32'(dout), 32'h00);
        push(8'hD1); push(8'hD2);
        pop(); pop();
        check("midrst_readback", 32'(dout), 32'hD2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic w;
            logic rd;
            r  = ($urandom_range(0, 199) != 0);
            w  = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 70 : 35));
            rd = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 35 : 70));
            cyc(r, w, rd, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
